// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline fetch side.
package arm_pipe_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] R15_OFFSET = 32'd8;
endpackage

// File: rtl/pipe_fetch_deco.sv
// IF/ID pipeline register: clr loads a bubble, en gates updates, an empty load becomes a bubble.
module pipe_fetch_deco
  import arm_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = arm_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        load_vld,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc8,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP;
      PCPlus8D <= RESET_PC + R15_OFFSET;
      ValidD   <= 1'b0;
    end else if (clr) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (en) begin
      if (load_vld) begin
        InstrD   <= load_instr;
        PCPlus8D <= load_pc8;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, keeps one imem read outstanding, feeds the IF/ID register.
module fetch_stage
  import arm_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = arm_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] ALUResultE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);
  fetch_state_t state;
  logic [31:0]  hold_q;
  logic         redirect;
  logic [31:0]  target;
  logic         deliver;
  logic [31:0]  deliver_dat;

  assign redirect  = BranchTakenE | PCSrcW;
  assign target    = BranchTakenE ? ALUResultE : ResultW;
  assign imem_req  = reset & (state == S_REQ) & ~redirect & ~StallD;
  assign imem_addr = PCF;

  // An instruction reaches IF/ID only when nothing redirects the PC in the same cycle.
  always_comb begin
    deliver     = 1'b0;
    deliver_dat = imem_rdata;
    if (!redirect && !StallD) begin
      if (state == S_WAIT && imem_valid) begin
        deliver = 1'b1;
      end else if (state == S_HOLD) begin
        deliver     = 1'b1;
        deliver_dat = hold_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_REQ;
      PCF    <= RESET_PC;
      hold_q <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect)     PCF   <= target;
          else if (!StallD) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect) begin
            PCF   <= target;
            state <= imem_valid ? S_REQ : S_DRAIN;
          end else if (imem_valid) begin
            if (StallD) begin
              hold_q <= imem_rdata;
              state  <= S_HOLD;
            end else begin
              PCF   <= PCF + PC_STEP;
              state <= S_REQ;
            end
          end
        end
        // The in-flight response belongs to a discarded PC; swallow it.
        S_DRAIN: begin
          if (redirect)   PCF   <= target;
          if (imem_valid) state <= S_REQ;
        end
        S_HOLD: begin
          if (redirect) begin
            PCF   <= target;
            state <= S_REQ;
          end else if (!StallD) begin
            PCF   <= PCF + PC_STEP;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  pipe_fetch_deco #(.RESET_PC(RESET_PC), .NOP(NOP_INSTR)) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .en        (~StallD),
    .clr       (FlushD),
    .load_vld  (deliver),
    .load_instr(deliver_dat),
    .load_pc8  (PCF + R15_OFFSET),
    .InstrD    (InstrD),
    .PCPlus8D  (PCPlus8D),
    .ValidD    (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        StallD = 1'b0, FlushD = 1'b0, BranchTakenE = 1'b0, PCSrcW = 1'b0;
  logic [31:0] ALUResultE = '0, ResultW = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, PCF, InstrD, PCPlus8D;

  int checks = 0, failures = 0;

  // Model: fetch PC, one in-flight read (possibly stale), one parked word, IF/ID contents.
  logic [31:0] m_pc, m_instr, m_pc8, m_held_d;
  bit          m_valid, m_inflight, m_stale, m_held;
  // Memory: one pending response after mem_lat cycles.
  bit          mem_pend;
  int          mem_cnt;
  int          mem_lat = 1;
  logic [31:0] mem_word;
  bit          fixed_mode = 1'b0;
  logic [31:0] fixed_word = 32'hE3A0_1005;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit st, input bit fl, input bit br, input logic [31:0] alu,
                       input bit pw, input logic [31:0] res);
    StallD = st; FlushD = fl; BranchTakenE = br; ALUResultE = alu; PCSrcW = pw; ResultW = res;
  endtask

  // Called at posedge+1; checks request at negedge, advances model at posedge, checks state after.
  task automatic tick();
    bit          redirect, exp_req, avail;
    logic [31:0] target, d, pc_old;
    #4;
    redirect = BranchTakenE | PCSrcW;
    target   = BranchTakenE ? ALUResultE : ResultW;
    exp_req  = !m_inflight && !m_held && !redirect && !StallD;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    avail = 1'b0; d = '0; pc_old = m_pc;
    if (redirect) begin
      m_pc   = target;
      m_held = 1'b0;
      if (m_inflight && imem_valid) begin m_inflight = 1'b0; m_stale = 1'b0; end
      else if (m_inflight) m_stale = 1'b1;
    end else if (m_inflight) begin
      if (imem_valid) begin
        m_inflight = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (StallD) begin m_held = 1'b1; m_held_d = mem_word; end
        else begin avail = 1'b1; d = mem_word; m_pc = m_pc + 32'd4; end
      end
    end else if (m_held) begin
      if (!StallD) begin avail = 1'b1; d = m_held_d; m_held = 1'b0; m_pc = m_pc + 32'd4; end
    end else if (exp_req) begin
      m_inflight = 1'b1; m_stale = 1'b0;
      mem_pend = 1'b1; mem_cnt = mem_lat;
      mem_word = fixed_mode ? fixed_word : $urandom;
    end
    if (FlushD) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!StallD) begin
      if (avail) begin m_instr = d; m_pc8 = pc_old + 32'd8; m_valid = 1'b1; end
      else begin m_instr = NOP; m_valid = 1'b0; end
    end
    #1;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin imem_valid = 1'b1; imem_rdata = mem_word; mem_pend = 1'b0; end
      else mem_cnt--;
    end
    chk("PCF", PCF, m_pc);
    chk("ValidD", 32'(ValidD), 32'(m_valid));
    chk("InstrD", InstrD, m_instr);
    if (m_valid) chk("PCPlus8D", PCPlus8D, m_pc8);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, '0, 0, '0);
    imem_valid = 1'b0;
    m_pc = '0; m_instr = NOP; m_pc8 = 32'd8; m_valid = 1'b0;
    m_inflight = 1'b0; m_stale = 1'b0; m_held = 1'b0; mem_pend = 1'b0;
    #1;
    chk("rst_PCF", PCF, 32'h0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCPlus8D", PCPlus8D, 32'h8);
    chk("rst_ValidD", 32'(ValidD), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 30 && (m_inflight || m_held); i++) tick();
    chk("idle_reached", 32'(m_inflight || m_held), 32'h0);
  endtask

  initial begin
    #2;
    do_reset();

    // 1: straight-line fetch with a 1-cycle memory
    fixed_mode = 1'b1; mem_lat = 1;
    tick(); tick();
    chk("t1_InstrD", InstrD, 32'hE3A0_1005);
    chk("t1_PCPlus8D", PCPlus8D, 32'h8);
    chk("t1_ValidD", 32'(ValidD), 32'h1);
    fixed_mode = 1'b0;
    for (int i = 0; i < 40 && !(m_pc == 32'h10 && m_inflight); i++) tick();
    chk("t2_reach_0x10", PCF, 32'h10);

    // 2: stall across the response for PC 0x10
    drive(1, 0, 0, '0, 0, '0);
    tick(); tick(); tick();
    chk("t2_hold_PCF", PCF, 32'h10);
    drive(0, 0, 0, '0, 0, '0);
    tick();
    chk("t2_PCPlus8D", PCPlus8D, 32'h18);
    chk("t2_ValidD", 32'(ValidD), 32'h1);
    chk("t2_next_pc", PCF, 32'h14);

    // 3: branch during a 3-cycle read; stale data must be dropped
    mem_lat = 3;
    tick();
    drive(0, 1, 1, 32'h100, 0, '0);
    tick();
    drive(0, 0, 0, '0, 0, '0);
    tick(); tick();
    chk("t3_no_stale", 32'(ValidD), 32'h0);
    chk("t3_PCF", PCF, 32'h100);
    go_idle();

    // 4: execute redirect beats writeback redirect
    drive(0, 1, 1, 32'h200, 1, 32'h300);
    tick();
    drive(0, 0, 0, '0, 0, '0);
    chk("t4_PCF", PCF, 32'h200);
    tick();

    // 5: flush wins over stall while data arrives
    mem_lat = 1;
    go_idle();
    tick();
    drive(1, 1, 0, '0, 0, '0);
    tick();
    chk("t5_InstrD", InstrD, NOP);
    chk("t5_ValidD", 32'(ValidD), 32'h0);
    drive(0, 0, 0, '0, 0, '0);
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(4, 1);
      drive(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 12) == 0, $urandom,
            ($urandom % 16) == 0, $urandom);
      tick();
    end
    drive(0, 0, 0, '0, 0, '0);

    // 6: async reset mid-read, then PC wrap-around
    mem_lat = 3;
    go_idle();
    tick();
    do_reset();
    tick();
    chk("t6_PCF", PCF, 32'h0);
    go_idle();
    mem_lat = 1;
    drive(0, 1, 1, 32'hFFFF_FFFC, 0, '0);
    tick();
    drive(0, 0, 0, '0, 0, '0);
    tick(); tick();
    chk("t6_wrap_PCPlus8D", PCPlus8D, 32'h4);
    chk("t6_wrap_PCF", PCF, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
